// File: rtl/fpu_mul_arbiter_if.sv
// rtl/fpu_mul_arbiter_if.sv - requester and multiplier handshake bundle for fpu_mul_arbiter
interface fpu_mul_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IW   = 3
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [31:0]        rsp_z;
    logic [IW-1:0]      grant_id;
    logic               busy;
    logic [31:0]        mul_a;
    logic               mul_a_stb;
    logic               mul_a_ack;
    logic [31:0]        mul_b;
    logic               mul_b_stb;
    logic               mul_b_ack;
    logic [31:0]        mul_z;
    logic               mul_z_stb;
    logic               mul_z_ack;

    modport master (
        input  req_valid, req_a, req_b, rsp_ready, mul_a_ack, mul_b_ack, mul_z, mul_z_stb,
        output req_ready, rsp_valid, rsp_z, grant_id, busy,
               mul_a, mul_a_stb, mul_b, mul_b_stb, mul_z_ack
    );

    modport slave (
        output req_valid, req_a, req_b, rsp_ready, mul_a_ack, mul_b_ack, mul_z, mul_z_stb,
        input  req_ready, rsp_valid, rsp_z, grant_id, busy,
               mul_a, mul_a_stb, mul_b, mul_b_stb, mul_z_ack
    );
endinterface

// File: rtl/fpu_mul_arbiter.sv
// rtl/fpu_mul_arbiter.sv - round-robin sequencer sharing one FPU multiplier; FPU_ARB_FIXED_PRIO_EN selects fixed priority
module fpu_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 3
) (
    input  logic              clk,
    input  logic              rst,
    fpu_mul_arbiter_if.master bus
);
    typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, RESP} state_t;

    state_t        state;
    logic [IW-1:0] base;
    logic [IW-1:0] winner;
    logic          found;
    logic [IW:0]   idx;
    logic [31:0]   win_a;
    logic [31:0]   win_b;

`ifdef FPU_ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [IW-1:0] ptr;
    assign base = ptr;
`endif

    // Cyclic search from base; the first valid requester encountered wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        win_a  = '0;
        win_b  = '0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, base} + (IW+1)'(k);
            if (idx >= (IW+1)'(NREQ))
                idx = idx - (IW+1)'(NREQ);
            for (int i = 0; i < NREQ; i++) begin
                if (!found && bus.req_valid[i] && idx == (IW+1)'(i)) begin
                    found  = 1'b1;
                    winner = IW'(i);
                    win_a  = bus.req_a[32*i +: 32];
                    win_b  = bus.req_b[32*i +: 32];
                end
            end
        end
    end

    assign bus.req_ready = (state == IDLE && found && !rst) ? (NREQ'(1) << winner) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.grant_id  <= '0;
            bus.rsp_z     <= '0;
            bus.rsp_valid <= '0;
            bus.busy      <= 1'b0;
            bus.mul_a     <= '0;
            bus.mul_b     <= '0;
            bus.mul_a_stb <= 1'b0;
            bus.mul_b_stb <= 1'b0;
            bus.mul_z_ack <= 1'b0;
`ifndef FPU_ARB_FIXED_PRIO_EN
            ptr           <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (found) begin
                    bus.mul_a     <= win_a;
                    bus.mul_b     <= win_b;
                    bus.grant_id  <= winner;
                    bus.mul_a_stb <= 1'b1;
                    bus.busy      <= 1'b1;
                    state         <= SEND_A;
                end
                SEND_A: if (bus.mul_a_ack) begin
                    bus.mul_a_stb <= 1'b0;
                    bus.mul_b_stb <= 1'b1;
                    state         <= SEND_B;
                end
                SEND_B: if (bus.mul_b_ack) begin
                    bus.mul_b_stb <= 1'b0;
                    bus.mul_z_ack <= 1'b1;
                    state         <= WAIT_Z;
                end
                WAIT_Z: if (bus.mul_z_stb) begin
                    bus.mul_z_ack <= 1'b0;
                    bus.rsp_z     <= bus.mul_z;
                    bus.rsp_valid <= NREQ'(1) << bus.grant_id;
                    state         <= RESP;
                end
                // rsp_valid is one-hot on grant_id, so masking ignores other requesters.
                RESP: if (|(bus.rsp_ready & bus.rsp_valid)) begin
                    bus.rsp_valid <= '0;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
`ifndef FPU_ARB_FIXED_PRIO_EN
                    ptr <= (bus.grant_id == IW'(NREQ - 1)) ? '0 : bus.grant_id + IW'(1);
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// tb/tb_fpu_mul_arbiter.sv - self-checking bench for fpu_mul_arbiter with a phase-level reference model
module tb_fpu_mul_arbiter;
    localparam int NREQ = 4;
    localparam int IW   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #10 clk = ~clk;

    fpu_mul_arbiter_if #(.NREQ(NREQ), .IW(IW)) bus ();
    fpu_mul_arbiter #(.NREQ(NREQ), .IW(IW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] ra [NREQ];
    logic [31:0] rb [NREQ];
    logic [NREQ-1:0] oneshot;
    logic [NREQ-1:0] rr_snap = '0;
    int n_checks = 0;
    int n_fail = 0;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[32*i +: 32] = ra[i];
            bus.req_b[32*i +: 32] = rb[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] tbl(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3FC00000, 32'h40000000}: return 32'h40400000;
            {32'h40400000, 32'h40800000}: return 32'h41400000;
            {32'h7F800000, 32'hBF800000}: return 32'hFF800000;
            {32'h00000001, 32'h3F800000}: return 32'h00000001;
            {32'h3F800000, 32'h7FC00000}: return 32'h7FC00000;
            {32'hBF000000, 32'h40000000}: return 32'hBF800000;
            default: return a ^ b;
        endcase
    endfunction

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        int s;
`ifdef FPU_ARB_FIXED_PRIO_EN
        s = 0;
`else
        s = p;
`endif
        for (int k = 0; k < NREQ; k++)
            if (v[(s + k) % NREQ]) return (s + k) % NREQ;
        return 0;
    endfunction

    // Reference model: phase 0 idle, 1 send A, 2 send B, 3 wait Z, 4 respond.
    int ph = 0;
    int m_ptr = 0;
    int m_gid = 0;
    bit [31:0] m_a, m_b, m_z;
    int gq[$];
    bit [31:0] zq[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= 0; m_ptr <= 0; m_gid <= 0; m_a <= '0; m_b <= '0; m_z <= '0;
        end else begin
            case (ph)
                0: if (|bus.req_valid) begin
                    m_gid <= pick(bus.req_valid, m_ptr);
                    m_a   <= ra[pick(bus.req_valid, m_ptr)];
                    m_b   <= rb[pick(bus.req_valid, m_ptr)];
                    ph    <= 1;
                end
                1: if (bus.mul_a_ack) ph <= 2;
                2: if (bus.mul_b_ack) ph <= 3;
                3: if (bus.mul_z_stb) begin m_z <= bus.mul_z; ph <= 4; end
                default: if (bus.rsp_ready[m_gid]) begin
                    gq.push_back(m_gid);
                    zq.push_back(m_z);
                    m_ptr <= (m_gid + 1) % NREQ;
                    ph <= 0;
                end
            endcase
        end
    end

    // Multiplier model: ack after a programmable wait, result after z_delay cycles.
    int a_wait = 0, b_wait = 0, z_delay = 0;
    int a_cnt = 0, b_cnt = 0, z_cnt = 0;
    int a_xfers = 0, b_xfers = 0;
    logic [31:0] a_cap = '0, b_cap = '0;

    always @(posedge clk) begin
        if (!rst && bus.mul_a_stb && bus.mul_a_ack) begin a_xfers <= a_xfers + 1; a_cap <= bus.mul_a; end
        if (!rst && bus.mul_b_stb && bus.mul_b_ack) begin b_xfers <= b_xfers + 1; b_cap <= bus.mul_b; end
    end

    initial begin
        bus.mul_a_ack = 1'b0; bus.mul_b_ack = 1'b0; bus.mul_z_stb = 1'b0; bus.mul_z = 32'hDEADBEEF;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.mul_a_ack = 1'b0; bus.mul_b_ack = 1'b0; bus.mul_z_stb = 1'b0;
                bus.mul_z = 32'hDEADBEEF; a_cnt = 0; b_cnt = 0; z_cnt = 0;
            end else begin
                if (bus.mul_a_stb) begin
                    if (a_cnt >= a_wait) bus.mul_a_ack = 1'b1;
                    else begin bus.mul_a_ack = 1'b0; a_cnt++; end
                end else begin bus.mul_a_ack = 1'b0; a_cnt = 0; end
                if (bus.mul_b_stb) begin
                    if (b_cnt >= b_wait) bus.mul_b_ack = 1'b1;
                    else begin bus.mul_b_ack = 1'b0; b_cnt++; end
                end else begin bus.mul_b_ack = 1'b0; b_cnt = 0; end
                if (bus.mul_z_ack && z_cnt >= z_delay) begin
                    bus.mul_z_stb = 1'b1; bus.mul_z = tbl(a_cap, b_cap);
                end else begin
                    if (bus.mul_z_ack) z_cnt++; else z_cnt = 0;
                    bus.mul_z_stb = 1'b0; bus.mul_z = 32'hDEADBEEF;
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus idle-gap tracking.
    bit track = 0, saw_busy = 0;
    int idle_run = 0, gaps = 0, gap_bad = 0, rr0_cycles = 0;

    always @(negedge clk) begin
        #3;
        chk("busy", 32'(bus.busy), (ph != 0) ? 32'd1 : 32'd0);
        chk("req_ready", 32'(bus.req_ready),
            (!rst && ph == 0 && |bus.req_valid) ? (32'd1 << pick(bus.req_valid, m_ptr)) : 32'd0);
        chk("rsp_valid", 32'(bus.rsp_valid), (ph == 4) ? (32'd1 << m_gid) : 32'd0);
        chk("grant_id", 32'(bus.grant_id), m_gid);
        chk("mul_a_stb", 32'(bus.mul_a_stb), (ph == 1) ? 32'd1 : 32'd0);
        chk("mul_b_stb", 32'(bus.mul_b_stb), (ph == 2) ? 32'd1 : 32'd0);
        chk("mul_z_ack", 32'(bus.mul_z_ack), (ph == 3) ? 32'd1 : 32'd0);
        chk("mul_a", bus.mul_a, m_a);
        chk("mul_b", bus.mul_b, m_b);
        chk("rsp_z", bus.rsp_z, m_z);
        if (track) begin
            if (!bus.busy) idle_run++;
            else begin
                if (saw_busy && idle_run > 0) begin gaps++; if (idle_run != 1) gap_bad++; end
                saw_busy = 1; idle_run = 0;
            end
        end
    end

    always @(negedge clk) begin
        #9;
        rr_snap <= bus.req_ready;
        if (bus.req_ready[0]) rr0_cycles <= rr0_cycles + 1;
    end

    task automatic step();
        @(negedge clk);
        #5;
        for (int i = 0; i < NREQ; i++)
            if (oneshot[i] && rr_snap[i]) bus.req_valid[i] = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int c = 0;
        while (gq.size() < n && c < budget) begin step(); c++; end
        chk(name, gq.size(), n);
    endtask

    function automatic int gq_at(input int i);
        return (gq.size() > i) ? gq[i] : -1;
    endfunction

    function automatic logic [31:0] zq_at(input int i);
        return (zq.size() > i) ? zq[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    int base, c, xa, xb;
    int exp_g2[6] = '{0, 1, 2, 3, 0, 1};
    logic [31:0] exp_z2[6] = '{32'h40400000, 32'h41400000, 32'hFF800000, 32'h00000001,
                               32'h40400000, 32'h41400000};
`ifdef FPU_ARB_FIXED_PRIO_EN
    int exp_g6[4] = '{0, 0, 0, 0};
`else
    int exp_g6[4] = '{0, 2, 0, 2};
`endif

    initial begin
        bus.req_valid = '0; bus.rsp_ready = '1; oneshot = '0;
        for (int i = 0; i < NREQ; i++) begin ra[i] = '0; rb[i] = '0; end
        #1 rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        #1;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_grant_id", 32'(bus.grant_id), 32'd0);
        chk("reset_rsp_z", bus.rsp_z, 32'd0);
        chk("reset_mul_a", bus.mul_a, 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);

        // Single request on port 0
        ra[0] = 32'h3FC00000; rb[0] = 32'h40000000;
        ra[1] = 32'h40400000; rb[1] = 32'h40800000;
        ra[2] = 32'h7F800000; rb[2] = 32'hBF800000;
        ra[3] = 32'h00000001; rb[3] = 32'h3F800000;
        step();
        oneshot = 4'b0001; rr0_cycles = 0; bus.req_valid = 4'b0001;
        wait_log(1, 40, "s1_done");
        chk("s1_grant", gq_at(0), 0);
        chk("s1_z", zq_at(0), 32'h40400000);
        chk("s1_rr0_pulses", rr0_cycles, 1);
        chk("s1_grant_id", 32'(bus.grant_id), 32'd0);

        // All four valid continuously after reset
        oneshot = '0;
        pulse_reset();
        base = gq.size();
        idle_run = 0; gaps = 0; gap_bad = 0; saw_busy = 0; track = 1;
        bus.req_valid = 4'b1111;
        wait_log(base + 6, 100, "s2_done");
        bus.req_valid = '0;
        track = 0;
        for (int k = 0; k < 6; k++) begin
            chk("s2_grant", gq_at(base + k), exp_g2[k]);
            chk("s2_z", zq_at(base + k), exp_z2[k]);
        end
        chk("s2_gaps", gaps, 5);
        chk("s2_gap_len", gap_bad, 0);

        // Response backpressure on port 1
        ra[1] = 32'h3F800000; rb[1] = 32'h7FC00000;
        bus.rsp_ready = 4'b1101; oneshot = 4'b0011;
        base = gq.size();
        bus.req_valid = 4'b0010;
        c = 0;
        while (!bus.rsp_valid[1] && c < 40) begin step(); c++; end
        chk("s3_rsp_seen", 32'(bus.rsp_valid), 32'h2);
        bus.req_valid[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("s3_hold_z", bus.rsp_z, 32'h7FC00000);
            chk("s3_hold_rr", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 4'b1111;
        wait_log(base + 2, 40, "s3_done");
        chk("s3_grant1", gq_at(base), 1);
        chk("s3_z1", zq_at(base), 32'h7FC00000);
        chk("s3_grant0", gq_at(base + 1), 0);
        chk("s3_z0", zq_at(base + 1), 32'h40400000);

        // Slow multiplier acks on port 2
        ra[2] = 32'hBF000000; rb[2] = 32'h40000000;
        a_wait = 3; b_wait = 2; z_delay = 1;
        xa = a_xfers; xb = b_xfers;
        base = gq.size(); oneshot = 4'b0100; bus.req_valid = 4'b0100;
        wait_log(base + 1, 60, "s4_done");
        chk("s4_grant", gq_at(base), 2);
        chk("s4_z", zq_at(base), 32'hBF800000);
        chk("s4_a_xfers", a_xfers - xa, 1);
        chk("s4_b_xfers", b_xfers - xb, 1);
        a_wait = 0; b_wait = 0;

        // Reset in the middle of WAIT_Z
        ra[3] = 32'h40400000; rb[3] = 32'h40800000;
        z_delay = 6; oneshot = 4'b1000; bus.req_valid = 4'b1000;
        c = 0;
        while (!bus.mul_z_ack && c < 40) begin step(); c++; end
        chk("s5_in_wait_z", 32'(bus.mul_z_ack), 32'd1);
        step();
        step();
        base = gq.size();
        rst = 1'b1;
        #2;
        chk("s5_rst_busy", 32'(bus.busy), 32'd0);
        chk("s5_rst_zack", 32'(bus.mul_z_ack), 32'd0);
        chk("s5_rst_mul_a", bus.mul_a, 32'd0);
        chk("s5_rst_mul_b", bus.mul_b, 32'd0);
        chk("s5_rst_gid", 32'(bus.grant_id), 32'd0);
        chk("s5_rst_rsp_z", bus.rsp_z, 32'd0);
        step();
        rst = 1'b0;
        z_delay = 0;
        oneshot = 4'b0101; bus.req_valid = 4'b0101;
        wait_log(base + 2, 60, "s5_done");
        chk("s5_grant_first", gq_at(base), 0);
        chk("s5_z_first", zq_at(base), 32'h40400000);
        chk("s5_grant_second", gq_at(base + 1), 2);
        chk("s5_z_second", zq_at(base + 1), 32'hBF800000);

        // Ports 0 and 2 continuously valid
        oneshot = '0;
        base = gq.size();
        bus.req_valid = 4'b0101;
        wait_log(base + 4, 80, "s6_done");
        bus.req_valid = '0;
        for (int k = 0; k < 4; k++)
            chk("s6_grant", gq_at(base + k), exp_g6[k]);
        c = 0;
        while (bus.busy && c < 40) begin step(); c++; end
        chk("s6_drain", 32'(bus.busy), 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
